// File: rtl/multi_cycle_control.sv
// multi_cycle_control: multi-cycle MIPS-style control FSM with memory wait timeout; optional ORI support via MULTI_CYCLE_ORI_EN
module multi_cycle_control #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       aluop1,
  output logic       aluop0,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_R = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J = 6'b000010;
`ifdef MULTI_CYCLE_ORI_EN
  localparam logic [5:0] OP_ORI = 6'b001101;
`endif
  typedef enum logic [3:0] {
`ifdef MULTI_CYCLE_ORI_EN
    ORIEX = 4'd10, ORIWB = 4'd11,
`endif
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9
  } state_t;
  state_t state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wait_st, timeout, illegal;
  // next state, latched opcode and consecutive-wait counter
  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    wait_st = state_q inside {FETCH, MEMRD, MEMWR};
    timeout = (TIMEOUT_CYCLES != 0) && wait_st && !mem_ready && (cnt_q == CW'(TIMEOUT_CYCLES));
    op_d = (state_q == DECODE) ? op : op_q;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
`ifdef MULTI_CYCLE_ORI_EN
          OP_ORI:       state_d = ORIEX;
`endif
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_d = mem_ready ? MEMWB : (timeout ? FETCH : MEMRD);
      MEMWR:  state_d = (mem_ready || timeout) ? FETCH : MEMWR;
      EXEC:   state_d = RWB;
`ifdef MULTI_CYCLE_ORI_EN
      ORIEX:  state_d = ORIWB;
`endif
      default: state_d = FETCH;
    endcase
    cnt_d = (state_d != state_q || timeout || !wait_st || mem_ready || TIMEOUT_CYCLES == 0) ? '0 : cnt_q + 1'b1;
  end
  // state registers; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      op_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
    end
  end
  // datapath strobes decoded from current state and mem_ready, all forced low in reset
  always_comb begin
    {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, regwrite, regdst, alusrca} = '0;
    {alusrcb, pcsource, aluop1, aluop0} = '0;
    illegal_op = !reset && illegal;
    mem_timeout = !reset && timeout;
    state = reset ? 4'd0 : state_q;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        DECODE: alusrcb = 2'b11;
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        MEMRD: begin
          memread = 1'b1;
          iord = 1'b1;
        end
        MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        MEMWR: begin
          memwrite = 1'b1;
          iord = 1'b1;
        end
        EXEC: begin
          alusrca = 1'b1;
          aluop1 = 1'b1;
        end
        RWB: begin
          regwrite = 1'b1;
          regdst = 1'b1;
        end
        BRANCH: begin
          alusrca = 1'b1;
          aluop0 = 1'b1;
          pcwritecond = 1'b1;
          pcsource = 2'b01;
        end
        JUMP: begin
          pcwrite = 1'b1;
          pcsource = 2'b10;
        end
`ifdef MULTI_CYCLE_ORI_EN
        ORIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          aluop1 = 1'b1;
        end
        ORIWB: regwrite = 1'b1;
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: instruction-level scoreboard bench for multi_cycle_control
module tb_multi_cycle_control;
  localparam int T = 15;
  localparam logic [3:0] S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MW = 4, S_WR = 5, S_EX = 6, S_RW = 7, S_BR = 8, S_J = 9, S_OX = 10, S_OW = 11;
  localparam logic [17:0] PCW = 18'h20000, PCWC = 18'h10000, IORD = 18'h08000, MRD = 18'h04000, MWR = 18'h02000, M2R = 18'h01000;
  localparam logic [17:0] IRW = 18'h00800, RW = 18'h00400, RDST = 18'h00200, ASA = 18'h00100, ASB1 = 18'h00040, ASB2 = 18'h00080, ASB3 = 18'h000c0;
  localparam logic [17:0] PCS1 = 18'h00010, PCS2 = 18'h00020, AOP1 = 18'h00008, AOP0 = 18'h00004, ILL = 18'h00002, TMO = 18'h00001;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100, JMP = 6'b000010, ORI = 6'b001101;
  logic clk = 0, reset = 1, mem_ready = 0;
  logic [5:0] op = 0;
  logic pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, regwrite, regdst, alusrca, aluop1, aluop0, illegal_op, mem_timeout;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] state;
  logic [21:0] sb[$];
  int compared = 0, mismatched = 0;
  multi_cycle_control #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready), .pcwrite(pcwrite), .pcwritecond(pcwritecond),
    .iord(iord), .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg), .irwrite(irwrite), .regwrite(regwrite),
    .regdst(regdst), .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource), .aluop1(aluop1), .aluop0(aluop0),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state));
  always #5 clk = ~clk;
  function automatic logic [17:0] strobes(input logic [3:0] s, input bit mr);
    case (s)
      S_F:  return MRD | ASB1 | (mr ? (IRW | PCW) : 18'h0);
      S_D:  return ASB3;
      S_MA: return ASA | ASB2;
      S_MR: return MRD | IORD;
      S_MW: return RW | M2R;
      S_WR: return MWR | IORD;
      S_EX: return ASA | AOP1;
      S_RW: return RW | RDST;
      S_BR: return ASA | AOP0 | PCWC | PCS1;
      S_J:  return PCW | PCS2;
      S_OX: return ASA | ASB2 | AOP1;
      S_OW: return RW;
      default: return 18'h0;
    endcase
  endfunction
  task automatic cyc(input logic r, input logic [5:0] o, input logic mr, input logic [21:0] e);
    @(posedge clk);
    #1;
    reset = r;
    op = o;
    mem_ready = mr;
    sb.push_back(e);
  endtask
  task automatic step(input logic [5:0] o, input logic [3:0] s, input logic [17:0] extra);
    logic mr;
    mr = 1'($urandom);
    cyc(0, o, mr, {s, strobes(s, mr) | extra});
  endtask
  task automatic mem_phase(input logic [5:0] o, input logic [3:0] s, input int w, output bit to);
    for (int k = 0; ; k++) begin
      if (k >= w) begin
        cyc(0, o, 1, {s, strobes(s, 1)});
        to = 0;
        return;
      end else if (T != 0 && k == T) begin
        cyc(0, o, 0, {s, strobes(s, 0) | TMO});
        to = 1;
        return;
      end
      cyc(0, o, 0, {s, strobes(s, 0)});
    end
  endtask
  task automatic instr(input logic [5:0] o, input int wf, input int wm);
    bit to;
    int w;
    bit legal;
    w = wf;
    forever begin
      mem_phase(o, S_F, w, to);
      if (!to) break;
      w -= T + 1;
    end
`ifdef MULTI_CYCLE_ORI_EN
    legal = o inside {LW, SW, RT, BEQ, JMP, ORI};
`else
    legal = o inside {LW, SW, RT, BEQ, JMP};
`endif
    step(o, S_D, legal ? 18'h0 : ILL);
    if (o == LW || o == SW) begin
      step(o, S_MA, 0);
      mem_phase(o, o == LW ? S_MR : S_WR, wm, to);
      if (!to && o == LW) step(o, S_MW, 0);
    end else if (o == RT) begin
      step(o, S_EX, 0);
      step(o, S_RW, 0);
    end else if (o == BEQ) step(o, S_BR, 0);
    else if (o == JMP) step(o, S_J, 0);
    else if (legal) begin
      step(o, S_OX, 0);
      step(o, S_OW, 0);
    end
  endtask
  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1, 6'($urandom), 1'($urandom), 22'h0);
  endtask
  function automatic int rand_wait();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 3));
  endfunction
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [21:0] e, a;
      e = sb.pop_front();
      a = {state, pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, regwrite, regdst, alusrca,
           alusrcb, pcsource, aluop1, aluop0, illegal_op, mem_timeout};
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL cycle_outputs t=%0t state/strobes got %h expected %h", $time, a, e);
      end
    end
  end
  initial begin
    logic [5:0] ops[8];
    hold_reset(2);
    instr(LW, 0, 0);
    instr(SW, 0, 3);
    instr(RT, 0, 0);
    instr(BEQ, 0, 0);
    instr(JMP, 0, 0);
    instr(6'b111111, 0, 0);
    instr(ORI, 0, 0);
    instr(LW, 20, 0);
    instr(LW, 1, 17);
    instr(SW, 2, 16);
    instr(SW, 0, 15);
    instr(SW, 0, 0);
    cyc(0, SW, 1, {S_F, strobes(S_F, 1)});
    cyc(0, SW, 1, {S_D, strobes(S_D, 1)});
    cyc(0, SW, 0, {S_MA, strobes(S_MA, 0)});
    cyc(0, SW, 0, {S_WR, strobes(S_WR, 0)});
    cyc(0, SW, 0, {S_WR, strobes(S_WR, 0)});
    hold_reset(2);
    ops = '{LW, SW, RT, BEQ, JMP, ORI, 6'b111111, 6'b0};
    for (int i = 0; i < 150; i++) begin
      logic [5:0] o;
      o = ops[$urandom_range(0, 7)];
      if (o == 6'b0 && $urandom_range(0, 1) == 1) o = 6'($urandom);
      instr(o, rand_wait(), rand_wait());
      if ($urandom_range(0, 29) == 0) hold_reset(1);
    end
    repeat (3) @(posedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
